// File: rtl/tempo_key_controller.sv
// Front-panel BPM key sequencer: debounced up/down/preset levels -> one-cycle step/preset commands with auto-repeat.
// Latency: a command appears the cycle after the triggering sample; no backpressure, commands are unconditional pulses.
module tempo_key_controller #(
    parameter int unsigned HOLD_DELAY_CYC   = 25000000,
    parameter int unsigned REPEAT_CYC       = 5000000,
    parameter int unsigned FAST_REPEAT_CYC  = 2000000,
    parameter int unsigned FAST_AFTER_STEPS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic key_up,
    input  logic key_down,
    input  logic key_preset,
    output logic step_pulse,
    output logic step_up,
    output logic preset_pulse,
    output logic repeating
);

    localparam int unsigned MAX_A  = (HOLD_DELAY_CYC > REPEAT_CYC) ? HOLD_DELAY_CYC : REPEAT_CYC;
    localparam int unsigned MAX_P  = (MAX_A > FAST_REPEAT_CYC) ? MAX_A : FAST_REPEAT_CYC;
    localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int unsigned RW     = $clog2(FAST_AFTER_STEPS + 2);

    // Counter holds "cycles since the step pulse"; a step fires when it reaches period-1.
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_DELAY_CYC - 1);
    localparam logic [CW-1:0] REP_LAST    = CW'(REPEAT_CYC - 1);
    localparam logic [CW-1:0] FAST_LAST   = CW'(FAST_REPEAT_CYC - 1);
    localparam logic [RW-1:0] RCNT_SLOW   = RW'(FAST_AFTER_STEPS);
    localparam logic [RW-1:0] RCNT_MAX    = RW'(FAST_AFTER_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic          preset_prev;
    logic          step_d, up_d, preset_d;
    logic          active_key, opposite_key, preset_rise, all_released;
    logic [CW-1:0] period_last;

    // step_up doubles as the direction of the key currently being held.
    assign active_key   = step_up ? key_up : key_down;
    assign opposite_key = step_up ? key_down : key_up;
    assign preset_rise  = key_preset & ~preset_prev;
    assign all_released = ~(key_up | key_down | key_preset);

    assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    assign rcnt_inc = (rcnt_q >= RCNT_MAX) ? RCNT_MAX : rcnt_q + RW'(1);

    always_comb begin
        period_last = HOLD_LAST;
        if (state_q == REPEAT) begin
            period_last = (rcnt_q <= RCNT_SLOW) ? REP_LAST : FAST_LAST;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        rcnt_d   = rcnt_q;
        step_d   = 1'b0;
        up_d     = step_up;
        preset_d = 1'b0;

        if (preset_rise) begin
            preset_d = 1'b1;
            state_d  = LOCKOUT;
            cnt_d    = '0;
            rcnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    rcnt_d = '0;
                    if (key_up && key_down) begin
                        state_d = LOCKOUT;
                    end else if (key_up || key_down) begin
                        step_d  = 1'b1;
                        up_d    = key_up;
                        state_d = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    // A conflicting key wins over a simultaneous release.
                    if (opposite_key) begin
                        state_d = LOCKOUT;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                    end else if (!active_key) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                    end else if (cnt_q >= period_last) begin
                        step_d  = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                        rcnt_d  = rcnt_inc;
                    end
                end
                LOCKOUT: begin
                    cnt_d  = '0;
                    rcnt_d = '0;
                    if (all_released) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = LOCKOUT;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOCKOUT;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            step_pulse   <= 1'b0;
            step_up      <= 1'b0;
            preset_pulse <= 1'b0;
            repeating    <= 1'b0;
            // Treat preset as already high so a key held through reset is not seen as a rise.
            preset_prev  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            step_pulse   <= step_d;
            step_up      <= up_d;
            preset_pulse <= preset_d;
            repeating    <= (state_q == REPEAT) && (state_d == REPEAT);
            preset_prev  <= key_preset;
        end
    end

endmodule

// File: tb/tb_tempo_key_controller.sv
// Bench for tempo_key_controller: directed scenarios plus randomized key traffic against a timestamp-based model.
module tb_tempo_key_controller;

    localparam int H  = 8;
    localparam int R  = 4;
    localparam int FR = 2;
    localparam int FA = 3;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_REP  = 2;
    localparam int M_LOCK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_up = 1'b0;
    logic key_down = 1'b0;
    logic key_preset = 1'b0;
    logic step_pulse, step_up, preset_pulse, repeating;

    tempo_key_controller #(
        .HOLD_DELAY_CYC  (H),
        .REPEAT_CYC      (R),
        .FAST_REPEAT_CYC (FR),
        .FAST_AFTER_STEPS(FA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_preset  (key_preset),
        .step_pulse  (step_pulse),
        .step_up     (step_up),
        .preset_pulse(preset_pulse),
        .repeating   (repeating)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: mode, timestamp of the last step pulse, steps taken since entering repeat.
    int   gcyc    = 0;
    int   m_mode  = M_LOCK;
    int   m_last  = 0;
    int   m_nrep  = 0;
    logic m_dir   = 1'b0;
    logic m_prevp = 1'b1;
    logic [3:0] expv = 4'b0000;
    wire  [3:0] obs  = {step_pulse, step_up, preset_pulse, repeating};

    task automatic model_update(input logic u, input logic d, input logic p, input logic r);
        int   nowo, gap, old;
        logic act, opp, e_step, e_pre, e_rep;
        nowo   = gcyc + 1;
        old    = m_mode;
        e_step = 1'b0;
        e_pre  = 1'b0;
        if (r) begin
            m_mode  = M_LOCK;
            m_dir   = 1'b0;
            m_nrep  = 0;
            m_prevp = 1'b1;
            e_rep   = 1'b0;
        end else begin
            if (p && !m_prevp) begin
                e_pre  = 1'b1;
                m_mode = M_LOCK;
            end else if (old == M_IDLE) begin
                if (u && d) begin
                    m_mode = M_LOCK;
                end else if (u || d) begin
                    e_step = 1'b1;
                    m_dir  = u;
                    m_last = nowo;
                    m_nrep = 0;
                    m_mode = M_HOLD;
                end
            end else if (old == M_HOLD || old == M_REP) begin
                act = m_dir ? u : d;
                opp = m_dir ? d : u;
                if (old == M_HOLD) gap = H;
                else if (m_nrep <= FA) gap = R;
                else gap = FR;
                if (opp) begin
                    m_mode = M_LOCK;
                end else if (!act) begin
                    m_mode = M_IDLE;
                end else if (nowo - m_last == gap) begin
                    e_step = 1'b1;
                    m_last = nowo;
                    m_nrep = (m_nrep + 1 > FA + 1) ? FA + 1 : m_nrep + 1;
                    m_mode = M_REP;
                end
            end else begin
                if (!u && !d && !p) m_mode = M_IDLE;
            end
            e_rep   = (old == M_REP) && (m_mode == M_REP);
            m_prevp = p;
        end
        expv = {e_step, m_dir, e_pre, e_rep};
    endtask

    // Drive one sample cycle; on return the DUT outputs belong to the following cycle.
    task automatic tick(input logic u, input logic d, input logic p, input logic r);
        @(negedge clk);
        key_up     = u;
        key_down   = d;
        key_preset = p;
        rst        = r;
        model_update(u, d, p, r);
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    task automatic settle();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int t = 0; t < 3; t++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL reset t=%0d got=%b want=0000", t, obs);
            end
        end
        settle();
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", obs, expv);
        end
    endtask

    // Pulses encoded as cycle*2+direction.
    task automatic test_tap();
        int pq[$];
        settle();
        for (int t = 0; t < 8; t++) begin
            tick((t <= 2) || (t == 4), 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL tap cyc=%0d got=%b want=%b", t + 1, obs, expv);
            end
            if (step_pulse) pq.push_back((t + 1) * 2 + int'(step_up));
        end
        checks++;
        if (pq.size() != 2 || pq[0] != 3 || pq[1] != 11) begin
            failures++;
            $display("FAIL tap_pulses got=%p want='{3,11}", pq);
        end
    endtask

    task automatic test_hold();
        int pq[$];
        int want[9] = '{1, 9, 13, 17, 21, 23, 25, 27, 29};
        int c;
        settle();
        for (int t = 0; t < 35; t++) begin
            tick(t <= 29, 1'b0, 1'b0, 1'b0);
            c = t + 1;
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL hold cyc=%0d got=%b want=%b", c, obs, expv);
            end
            checks++;
            if (repeating !== ((c >= 10) && (c <= 30))) begin
                failures++;
                $display("FAIL hold_repeating cyc=%0d got=%b", c, repeating);
            end
            if (step_pulse) begin
                pq.push_back(c);
                checks++;
                if (step_up !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_dir cyc=%0d got=%b want=1", c, step_up);
                end
            end
        end
        checks++;
        if (pq.size() != 9) begin
            failures++;
            $display("FAIL hold_count got=%0d want=9", pq.size());
        end
        for (int i = 0; i < 9 && i < pq.size(); i++) begin
            checks++;
            if (pq[i] != want[i]) begin
                failures++;
                $display("FAIL hold_pulse%0d got=%0d want=%0d", i, pq[i], want[i]);
            end
        end
    endtask

    task automatic test_conflict();
        int pq[$];
        settle();
        for (int t = 0; t < 18; t++) begin
            tick(((t >= 5) && (t <= 11)) || (t == 14), t <= 8, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL conflict cyc=%0d got=%b want=%b", t + 1, obs, expv);
            end
            if (step_pulse) pq.push_back((t + 1) * 2 + int'(step_up));
        end
        checks++;
        if (pq.size() != 2 || pq[0] != 2 || pq[1] != 31) begin
            failures++;
            $display("FAIL conflict_pulses got=%p want='{2,31}", pq);
        end
    endtask

    task automatic test_preset();
        int pq[$];
        int prq[$];
        settle();
        for (int t = 0; t < 26; t++) begin
            tick((t <= 19) || (t == 23), 1'b0, (t >= 12) && (t <= 14), 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL preset cyc=%0d got=%b want=%b", t + 1, obs, expv);
            end
            checks++;
            if (step_pulse && preset_pulse) begin
                failures++;
                $display("FAIL preset_overlap cyc=%0d got=11 want=not both", t + 1);
            end
            if (step_pulse) pq.push_back((t + 1) * 2 + int'(step_up));
            if (preset_pulse) prq.push_back(t + 1);
        end
        checks++;
        if (pq.size() != 3 || pq[0] != 3 || pq[1] != 19 || pq[2] != 49) begin
            failures++;
            $display("FAIL preset_steps got=%p want='{3,19,49}", pq);
        end
        checks++;
        if (prq.size() != 1 || prq[0] != 13) begin
            failures++;
            $display("FAIL preset_pulse got=%p want='{13}", prq);
        end
    endtask

    task automatic test_reset_held();
        int pq[$];
        logic u, d, r;
        settle();
        for (int t = 0; t < 40; t++) begin
            u = (t <= 11);
            r = (t >= 12) && (t <= 14);
            d = ((t >= 12) && (t <= 34)) || (t == 37);
            tick(u, d, 1'b0, r);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL reset_held cyc=%0d got=%b want=%b", t + 1, obs, expv);
            end
            if (t == 12) begin
                checks++;
                if (obs !== 4'b0000) begin
                    failures++;
                    $display("FAIL reset_midrepeat got=%b want=0000", obs);
                end
            end
            if (step_pulse) pq.push_back((t + 1) * 2 + int'(step_up));
        end
        checks++;
        if (pq.size() != 3 || pq[0] != 3 || pq[1] != 19 || pq[2] != 76) begin
            failures++;
            $display("FAIL reset_held_pulses got=%p want='{3,19,76}", pq);
        end
    endtask

    task automatic test_simultaneous();
        int pq[$];
        settle();
        for (int t = 0; t < 13; t++) begin
            tick((t <= 7) || (t == 10), t <= 3, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL simultaneous cyc=%0d got=%b want=%b", t + 1, obs, expv);
            end
            if (step_pulse) pq.push_back((t + 1) * 2 + int'(step_up));
        end
        checks++;
        if (pq.size() != 1 || pq[0] != 23) begin
            failures++;
            $display("FAIL simultaneous_pulses got=%p want='{23}", pq);
        end
    endtask

    task automatic test_random();
        logic u, d, p, r;
        u = 1'b0;
        d = 1'b0;
        p = 1'b0;
        settle();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) u = ~u;
            if ($urandom_range(23) == 0) d = ~d;
            if ($urandom_range(59) == 0) p = ~p;
            r = ($urandom_range(499) == 0);
            tick(u, d, p, r);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL random i=%0d in=%b%b%b%b got=%b want=%b", i, u, d, p, r, obs, expv);
            end
            checks++;
            if (step_pulse && preset_pulse) begin
                failures++;
                $display("FAIL random_overlap i=%0d got=11 want=not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tap();
        test_hold();
        test_conflict();
        test_preset();
        test_reset_held();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
